text_periph_bridge: RTL and testbench

- Memory-mapped text output peripheral that sits directly downstream of the cpu bus port and consumes its bus strobe, write-enable, address and write data.
- Decodes a small register window at TEXT_PERIPH_BASE and buffers written characters in a FIFO.
- Drains characters over a valid/ready stream to the text display/UART, and returns read data plus a data-ready pulse to the cpu.

---
 rtl/text_periph_bridge_pkg.sv | 39 +++
 rtl/text_periph_bridge_fifo.sv | 75 +++++++
 rtl/text_periph_bridge.sv | 164 ++++++++++++++++
 tb/tb_text_periph_bridge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/text_periph_bridge_pkg.sv
// Shared constants and types for the memory-mapped text output peripheral:
// register offsets, STATUS/CTRL bit positions, default base address, FSM states.
package text_periph_bridge_pkg;

  localparam logic [31:0] TEXT_PERIPH_BASE = 32'h0000_FE00;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_STALL  = 2'd2
  } bridge_state_e;

  // Assemble the STATUS word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic ovf, input logic [7:0] count);
    logic [31:0] word;
    word = 32'h0000_0000;
    word[STATUS_EMPTY_BIT] = empty;
    word[STATUS_FULL_BIT]  = full;
    word[STATUS_OVF_BIT]   = ovf;
    word[STATUS_COUNT_LSB +: 8] = count;
    return word;
  endfunction

endpackage

// File: rtl/text_periph_bridge_fifo.sv
// Byte FIFO with extra-MSB pointers (full vs. empty distinguished by wrap bit),
// synchronous flush that beats push, and a registered head with no fall-through.
module sync_fifo_8 #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_cpu_clk,
  input  logic                  i_rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [7:0]            head,
  output logic                  empty,
  output logic                  full,
  output logic                  empty_next,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] PTR_ZERO = {(DEPTH_LOG2 + 1){1'b0}};

  logic [7:0]          mem_r [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_r;
  logic [DEPTH_LOG2:0] rd_ptr_r;
  logic [DEPTH_LOG2:0] wr_next_s;
  logic [DEPTH_LOG2:0] rd_next_s;
  logic                do_push_s;
  logic                do_pop_s;
  logic                bypass_s;
  logic [7:0]          head_r;

  // Flags, accepted push/pop, next pointers and head-bypass select.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = ((wr_ptr_r ^ rd_ptr_r) == FULL_XOR);
    count     = wr_ptr_r - rd_ptr_r;
    do_pop_s  = pop & ~empty & ~flush;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    do_push_s = push & (~full | do_pop_s) & ~flush;
    if (flush) begin
      wr_next_s = PTR_ZERO;
      rd_next_s = PTR_ZERO;
    end else begin
      wr_next_s = wr_ptr_r + {{DEPTH_LOG2{1'b0}}, do_push_s};
      rd_next_s = rd_ptr_r + {{DEPTH_LOG2{1'b0}}, do_pop_s};
    end
    empty_next = (wr_next_s == rd_next_s);
    // The byte being written lands exactly where the next head is read from.
    bypass_s   = do_push_s & (wr_ptr_r[DEPTH_LOG2-1:0] == rd_next_s[DEPTH_LOG2-1:0]);
  end

  // Pointer and registered-head update.
  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      head_r   <= 8'h00;
    end else begin
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      head_r   <= bypass_s ? push_data : mem_r[rd_next_s[DEPTH_LOG2-1:0]];
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge i_cpu_clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data;
    end
  end

  assign head = head_r;

endmodule

// File: rtl/text_periph_bridge.sv
// Text output peripheral on the cpu bus: decodes a 16-byte register window,
// buffers written characters and streams them out over valid/ready.
module text_periph_bridge
  import text_periph_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = TEXT_PERIPH_BASE,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic        i_cpu_clk,
  input  logic        i_rst,
  input  logic        i_bus_clk,
  input  logic        i_bus_we,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_data,
  output logic [31:0] o_bus_data,
  output logic        o_bus_data_ready,
  output logic        o_char_valid,
  output logic [7:0]  o_char,
  input  logic        i_char_ready,
  output logic        o_irq
);

  bridge_state_e state_r;
  logic          bus_prev_r;
  logic [1:0]    off_r;
  logic          we_r;
  logic [7:0]    wdata_r;
  logic          ctrl_en_r;
  logic          ctrl_irq_en_r;
  logic          flush_r;
  logic          ovf_r;
  logic [31:0]   bus_data_r;
  logic          bus_ready_r;
  logic          char_valid_r;
  logic          irq_r;

  logic                       req_s;
  logic                       hit_s;
  logic                       data_wr_s;
  logic                       ctrl_wr_s;
  logic                       ctrl_en_next_s;
  logic                       irq_en_next_s;
  logic                       fifo_push_s;
  logic                       fifo_pop_s;
  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_next_s;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count_s;
  logic [7:0]                 fifo_head_s;
  logic [31:0]                status_s;

  sync_fifo_8 #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .i_cpu_clk  (i_cpu_clk),
    .i_rst      (i_rst),
    .push       (fifo_push_s),
    .push_data  (wdata_r),
    .pop        (fifo_pop_s),
    .flush      (flush_r),
    .head       (fifo_head_s),
    .empty      (fifo_empty_s),
    .full       (fifo_full_s),
    .empty_next (fifo_empty_next_s),
    .count      (fifo_count_s)
  );

  // Strobe edge, address decode, FIFO handshakes and next-cycle CTRL view.
  always_comb begin
    req_s          = i_bus_clk & ~bus_prev_r;
    hit_s          = (i_bus_addr[31:4] == BASE_ADDR[31:4]);
    fifo_pop_s     = char_valid_r & i_char_ready;
    data_wr_s      = (state_r == ST_ACCESS) & we_r & (off_r == REG_DATA);
    ctrl_wr_s      = (state_r == ST_ACCESS) & we_r & (off_r == REG_CTRL);
    // A stalled write pushes only once the pop of an earlier cycle left room.
    fifo_push_s    = (data_wr_s & (~fifo_full_s | fifo_pop_s)) |
                     ((state_r == ST_STALL) & ~fifo_full_s);
    ctrl_en_next_s = ctrl_wr_s ? wdata_r[CTRL_EN_BIT] : ctrl_en_r;
    irq_en_next_s  = ctrl_wr_s ? wdata_r[CTRL_IRQ_EN_BIT] : ctrl_irq_en_r;
    status_s       = pack_status(fifo_empty_s, fifo_full_s, ovf_r, 8'(fifo_count_s));
  end

  // Bus FSM with registered bus, stream-valid and interrupt outputs.
  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      bus_prev_r    <= 1'b0;
      off_r         <= 2'd0;
      we_r          <= 1'b0;
      wdata_r       <= 8'h00;
      ctrl_en_r     <= 1'b0;
      ctrl_irq_en_r <= 1'b0;
      flush_r       <= 1'b0;
      ovf_r         <= 1'b0;
      bus_data_r    <= 32'h0000_0000;
      bus_ready_r   <= 1'b0;
      char_valid_r  <= 1'b0;
      irq_r         <= 1'b0;
    end else begin
      bus_prev_r   <= i_bus_clk;
      bus_ready_r  <= 1'b0;
      flush_r      <= 1'b0;
      char_valid_r <= ~fifo_empty_next_s & ctrl_en_next_s;
      irq_r        <= fifo_empty_next_s & irq_en_next_s;
      case (state_r)
        ST_IDLE: begin
          if (req_s && hit_s) begin
            off_r   <= i_bus_addr[3:2];
            we_r    <= i_bus_we;
            wdata_r <= i_bus_data[7:0];
            state_r <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          state_r     <= ST_IDLE;
          bus_ready_r <= 1'b1;
          if (we_r) begin
            case (off_r)
              REG_DATA: begin
                if (fifo_full_s && !fifo_pop_s) begin
                  if (ctrl_en_r) begin
                    // Draining is possible, so hold the cpu until room appears.
                    state_r     <= ST_STALL;
                    bus_ready_r <= 1'b0;
                  end else begin
                    ovf_r <= 1'b1;
                  end
                end
              end
              REG_STATUS: ovf_r <= 1'b0;
              REG_CTRL: begin
                ctrl_en_r     <= wdata_r[CTRL_EN_BIT];
                ctrl_irq_en_r <= wdata_r[CTRL_IRQ_EN_BIT];
                flush_r       <= wdata_r[CTRL_FLUSH_BIT];
              end
              REG_RSVD: begin
              end
              default: begin
              end
            endcase
          end else begin
            case (off_r)
              REG_STATUS: bus_data_r <= status_s;
              REG_CTRL:   bus_data_r <= {30'd0, ctrl_irq_en_r, ctrl_en_r};
              default:    bus_data_r <= 32'h0000_0000;
            endcase
          end
        end
        ST_STALL: begin
          if (!fifo_full_s) begin
            bus_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign o_bus_data       = bus_data_r;
  assign o_bus_data_ready = bus_ready_r;
  assign o_char_valid     = char_valid_r;
  assign o_char           = fifo_head_s;
  assign o_irq            = irq_r;

endmodule

// File: tb/tb_text_periph_bridge.sv
// Directed bench for text_periph_bridge: register access, streaming, stall,
// overflow, flush/irq and asynchronous reset during a stalled write.
module tb_text_periph_bridge;

  localparam logic [31:0] A_DATA   = 32'h0000_FE00;
  localparam logic [31:0] A_STATUS = 32'h0000_FE04;
  localparam logic [31:0] A_CTRL   = 32'h0000_FE08;
  localparam logic [31:0] A_RSVD   = 32'h0000_FE0C;
  localparam logic [31:0] A_MISS   = 32'h0000_FE10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_clk = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = 32'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        char_ready = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] char_q[$];

  text_periph_bridge dut (
    .i_cpu_clk        (clk),
    .i_rst            (rst),
    .i_bus_clk        (bus_clk),
    .i_bus_we         (bus_we),
    .i_bus_addr       (bus_addr),
    .i_bus_data       (bus_wdata),
    .o_bus_data       (bus_rdata),
    .o_bus_data_ready (bus_ready),
    .o_char_valid     (char_valid),
    .o_char           (char_out),
    .i_char_ready     (char_ready),
    .o_irq            (irq)
  );

  always #5 clk = ~clk;

  // Log every character the sink accepts.
  always @(negedge clk) begin
    if (!rst && char_valid === 1'b1 && char_ready === 1'b1) char_q.push_back(char_out);
  end

  // One bus transaction; lat = cycles from req cycle to ready (-1 if none within budget).
  task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input int budget, output int lat, output logic [31:0] rdata);
    bus_we = we; bus_addr = addr; bus_wdata = data; bus_clk = 1'b1;
    @(posedge clk); #1; bus_clk = 1'b0;
    lat = -1; rdata = 32'h0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus_ready === 1'b1) begin
        lat = i; rdata = bus_rdata;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL rst_bus_data got %h exp 0", bus_rdata); end
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus_ready); end
    checks++; if (char_valid !== 1'b0 || char_out !== 8'h00) begin errors++; $display("FAIL rst_char got %b/%h exp 0/00", char_valid, char_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    @(posedge clk); #1; rst = 1'b0;
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL status_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL status_reset got %h exp 00000001", rd); end
    @(negedge clk);
    checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got %b exp 0", bus_ready); end
    @(posedge clk); #1;
    bus_xfer(1'b0, A_MISS, 32'h0, 6, lat, rd);
    checks++; if (lat !== -1) begin errors++; $display("FAIL miss_no_ready got %0d exp -1", lat); end
    checks++; if (bus_rdata !== 32'h0000_0001) begin errors++; $display("FAIL miss_data_held got %h exp 00000001", bus_rdata); end
    bus_xfer(1'b1, A_RSVD, 32'hFFFF_FFFF, 6, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rsvd_write_ack got %0d exp 2", lat); end
    bus_xfer(1'b0, A_RSVD, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_read got %h exp 0", rd); end
  endtask

  task automatic test_stream();
    int lat; logic [31:0] rd;
    bus_xfer(1'b1, A_CTRL, 32'h1, 6, lat, rd);
    char_ready = 1'b1;
    char_q.delete();
    bus_xfer(1'b1, A_DATA, 32'h41, 6, lat, rd);
    bus_xfer(1'b1, A_DATA, 32'h42, 6, lat, rd);
    bus_xfer(1'b1, A_DATA, 32'h43, 6, lat, rd);
    repeat (3) @(posedge clk); #1;
    checks++; if (char_q.size() !== 3) begin errors++; $display("FAIL stream_count got %0d exp 3", char_q.size()); end
    else begin
      checks++; if (char_q[0] !== 8'h41 || char_q[1] !== 8'h42 || char_q[2] !== 8'h43)
        begin errors++; $display("FAIL stream_order got %h %h %h exp 41 42 43", char_q[0], char_q[1], char_q[2]); end
    end
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL stream_status got %h exp 00000001", rd); end
    char_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat; int acks; logic [31:0] rd;
    char_q.delete();
    acks = 0;
    for (int i = 0; i < 16; i++) begin
      bus_xfer(1'b1, A_DATA, 32'(i), 6, lat, rd);
      if (lat == 2) acks++;
    end
    checks++; if (acks !== 16) begin errors++; $display("FAIL fill_acks got %0d exp 16", acks); end
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_1002) begin errors++; $display("FAIL full_status got %h exp 00001002", rd); end
    bus_xfer(1'b1, A_DATA, 32'h10, 6, lat, rd);
    checks++; if (lat !== -1) begin errors++; $display("FAIL stall_no_ready got %0d exp -1", lat); end
    char_ready = 1'b1;
    @(posedge clk); #1; char_ready = 1'b0;
    lat = -1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (bus_ready === 1'b1) begin lat = i; break; end
    end
    @(posedge clk); #1;
    checks++; if (lat === -1) begin errors++; $display("FAIL stall_release got none exp ready"); end
    checks++; if (char_q.size() !== 1 || char_q[0] !== 8'h00) begin errors++; $display("FAIL stall_pop got n=%0d exp one 00", char_q.size()); end
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_1002) begin errors++; $display("FAIL stall_status got %h exp 00001002", rd); end
  endtask

  task automatic test_overflow();
    int lat; int acks; logic [31:0] rd;
    bus_xfer(1'b1, A_CTRL, 32'h4, 6, lat, rd);
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL flush_status got %h exp 00000001", rd); end
    acks = 0;
    for (int i = 0; i < 17; i++) begin
      bus_xfer(1'b1, A_DATA, 32'h60 + 32'(i), 6, lat, rd);
      if (lat == 2) acks++;
    end
    checks++; if (acks !== 17) begin errors++; $display("FAIL ovf_acks got %0d exp 17", acks); end
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_1006) begin errors++; $display("FAIL ovf_status got %h exp 00001006", rd); end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL disabled_valid got %b exp 0", char_valid); end
    bus_xfer(1'b1, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (lat !== 2) begin errors++; $display("FAIL status_write_ack got %0d exp 2", lat); end
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_1002) begin errors++; $display("FAIL ovf_clear got %h exp 00001002", rd); end
  endtask

  task automatic test_flush_irq();
    int lat; logic [31:0] rd;
    bus_xfer(1'b1, A_CTRL, 32'h4, 6, lat, rd);
    for (int i = 0; i < 5; i++) bus_xfer(1'b1, A_DATA, 32'hA0 + 32'(i), 6, lat, rd);
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_0500) begin errors++; $display("FAIL five_status got %h exp 00000500", rd); end
    bus_xfer(1'b1, A_CTRL, 32'h5, 6, lat, rd);
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL flush_empty got %h exp 00000001", rd); end
    bus_xfer(1'b0, A_CTRL, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL ctrl_readback got %h exp 00000001", rd); end
    bus_xfer(1'b1, A_CTRL, 32'h2, 6, lat, rd);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    bus_xfer(1'b1, A_DATA, 32'h55, 6, lat, rd);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b exp 0", char_valid); end
  endtask

  task automatic test_reset_in_stall();
    int lat; int seen; logic [31:0] rd;
    bus_xfer(1'b1, A_CTRL, 32'h1, 6, lat, rd);
    for (int i = 0; i < 15; i++) bus_xfer(1'b1, A_DATA, 32'hC0 + 32'(i), 6, lat, rd);
    bus_xfer(1'b1, A_DATA, 32'hEE, 6, lat, rd);
    checks++; if (lat !== -1) begin errors++; $display("FAIL stall2_no_ready got %0d exp -1", lat); end
    checks++; if (char_valid !== 1'b1 || char_out !== 8'h55) begin errors++; $display("FAIL prestall_head got %b/%h exp 1/55", char_valid, char_out); end
    #2; rst = 1'b1; #1;
    checks++; if (bus_rdata !== 32'h0 || bus_ready !== 1'b0 || char_valid !== 1'b0 || char_out !== 8'h00 || irq !== 1'b0)
      begin errors++; $display("FAIL async_rst got %h %b %b %h %b exp all 0", bus_rdata, bus_ready, char_valid, char_out, irq); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_ready !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_ready got %0d exp 0", seen); end
    @(posedge clk); #1; rst = 1'b0;
    bus_xfer(1'b0, A_STATUS, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0000_0001 || lat !== 2) begin errors++; $display("FAIL post_rst_status got %h lat %0d exp 00000001 lat 2", rd, lat); end
    bus_xfer(1'b0, A_CTRL, 32'h0, 6, lat, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_rst_ctrl got %h exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_overflow();
    test_flush_irq();
    test_reset_in_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
